mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
- Shares one pipelined multiplier (start/done handshake, fixed LATENCY, one issue per cycle) among NUM_REQ requesters, e.g. several integer-square-root engines.
- Grants requests round-robin and drives the multiplier operands and start.
- Tracks the requester ID of every in-flight operation in an in-order tag FIFO.
- Routes each returning product to its owner with a one-cycle valid pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID width IDW = max(1, clog2(NUM_REQ)).
- WIDTH, 64, operand and product width.
- LATENCY, 8, multiplier cycles from start to done; the tag FIFO depth equals LATENCY.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high.
- req  in  NUM_REQ  per-requester request, held until granted.
- req_mcand  in  NUM_REQ*WIDTH  flattened multiplicands; slice i belongs to requester i.
- req_mplier  in  NUM_REQ*WIDTH  flattened multipliers.
- gnt  out  NUM_REQ  combinational one-hot grant; req[i]&gnt[i] means accepted this cycle.
- resp_valid  out  NUM_REQ  registered one-hot, one-cycle result pulse.
- resp_product  out  WIDTH  registered product; valid only while resp_valid is nonzero.
- mul_start  out  1  registered start to the multiplier.
- mul_mcand  out  WIDTH  registered operand A.
- mul_mplier  out  WIDTH  registered operand B.
- mul_product  in  WIDTH  multiplier result.
- mul_done  in  1  multiplier result valid.
- busy  out  NUM_REQ  registered; bit i is set while requester i has an operation outstanding.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset values:
  - gnt, resp_valid, busy, mul_start, err = 0.
  - resp_product, mul_mcand, mul_mplier = 0.
  - Tag FIFO empty.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has highest priority first.
- Eligibility: requester i is eligible when req[i]=1 and busy[i]=0. Each requester has at most one operation outstanding.
- Arbitration:
  - Search starts at pointer+1 mod NUM_REQ, wrapping.
  - The first eligible requester gets gnt.
  - At most one grant per cycle; no grant when none is eligible.
  - The pointer updates to the granted index only on a grant.
- Issue: on a grant in cycle T, in cycle T+1:
  - mul_start=1.
  - mul_mcand/mul_mplier = the granted requester's slices, sampled at T.
  - The granted ID is pushed into the tag FIFO.
  - busy[i] is set from T+1.
- mul_start is exactly one cycle per grant. Back-to-back grants produce back-to-back starts, so the pipeline issues one operation per cycle.
- Return, when mul_done=1 in cycle D:
  - Pop the FIFO head ID h.
  - In cycle D+1: resp_valid[h]=1 and resp_product = mul_product sampled at D.
  - busy[h] clears at D+1, so requester h is eligible again in cycle D+1.
- End-to-end: a grant at T produces resp_valid at T+LATENCY+2.
- Simultaneous push and pop in one cycle is legal; occupancy is unchanged.
- Occupancy never exceeds LATENCY. A push while full sets err and the push is dropped (no grant is suppressed).
- A mul_done with the FIFO empty sets err. That done is ignored and no resp_valid is produced.
- err stays set until reset.
- Operand changes on req_* after a grant have no effect on the issued operation.
- Reset mid-operation:
  - All state returns to reset values.
  - The FIFO is flushed and in-flight results are discarded.
  - The multiplier shares reset, so no stale done is expected.
  - The first cycle after reset may grant immediately.
- Products are truncated to WIDTH bits exactly as the multiplier delivers them; the arbiter does no arithmetic.

Test Plan:
- Single request: req[2]=1 with operands 3 and 5 at cycle 10 -> gnt[2] at 10, mul_start at 11, resp_valid[2]=1 with resp_product=15 at 20 (LATENCY=8); busy[2] high during cycles 11..19.
- All four requesting from reset, operands i+1 and i+1 -> grants in order 0,1,2,3 on consecutive cycles; products 1,4,9,16 appear on consecutive cycles at their owners.
- Requester 1 holds req continuously -> no second gnt[1] until the cycle its resp_valid[1] pulses; requester 3 is still granted meanwhile.
- Round-robin fairness: last grant was 2, then req=4'b0101 -> grant 0 next, then 2, alternating; no starvation over 100 cycles.
- Reset asserted 4 cycles after a grant -> busy, FIFO and err are 0; no resp_valid from the flushed operation; a new request is granted the cycle after reset deasserts.
- mul_done forced with the FIFO empty -> err=1 and stays 1, resp_valid stays 0; subsequent normal operations still complete correctly.

Source files
------------

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one pipelined multiplier among NUM_REQ requesters.
// An in-order tag FIFO remembers which requester owns each in-flight product.
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int LATENCY = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_mcand,
    input  logic [NUM_REQ*WIDTH-1:0] req_mplier,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_product,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_mcand,
    output logic [WIDTH-1:0]         mul_mplier,
    input  logic [WIDTH-1:0]         mul_product,
    input  logic                     mul_done,
    output logic [NUM_REQ-1:0]       busy,
    output logic                     err
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int CW  = $clog2(LATENCY + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [IDW-1:0]     ptr_reg;
    logic [NUM_REQ-1:0] busy_reg, busy_next;
    logic [NUM_REQ-1:0] resp_valid_reg;
    logic [WIDTH-1:0]   resp_product_reg;
    logic               mul_start_reg;
    logic [WIDTH-1:0]   mcand_reg, mplier_reg;
    logic               err_reg;

    logic [IDW-1:0]     tag_mem [LATENCY];
    logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]      count_reg;

    logic [NUM_REQ-1:0] eligible;
    logic [WIDTH-1:0]   mcand_slice  [NUM_REQ];
    logic [WIDTH-1:0]   mplier_slice [NUM_REQ];
    logic               gnt_any;
    logic [IDW-1:0]     gnt_id;
    logic               fifo_empty, fifo_full, push, pop, err_event;
    logic [IDW-1:0]     head_id;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign eligible[gi]     = req[gi] & ~busy_reg[gi];
            assign mcand_slice[gi]  = req_mcand[gi*WIDTH +: WIDTH];
            assign mplier_slice[gi] = req_mplier[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Two passes: indices above the pointer first, then wrap around to the rest.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && eligible[i] && (IDW'(i) > ptr_reg)) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && eligible[i] && (IDW'(i) <= ptr_reg)) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(i);
            end
        end
        if (reset) begin
            gnt_any = 1'b0;
        end
    end

    assign gnt = gnt_any ? (ONE_HOT << gnt_id) : '0;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CW'(LATENCY));
    assign pop        = mul_done && !fifo_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = gnt_any && (!fifo_full || pop);
    assign head_id    = tag_mem[rd_ptr_reg];
    assign err_event  = (mul_done && fifo_empty) || (gnt_any && fifo_full && !pop);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(LATENCY - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        busy_next = busy_reg;
        if (pop) begin
            busy_next = busy_next & ~(ONE_HOT << head_id);
        end
        if (push) begin
            busy_next = busy_next | (ONE_HOT << gnt_id);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= gnt_id;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_reg          <= IDW'(NUM_REQ - 1);
            busy_reg         <= '0;
            resp_valid_reg   <= '0;
            resp_product_reg <= '0;
            mul_start_reg    <= 1'b0;
            mcand_reg        <= '0;
            mplier_reg       <= '0;
            err_reg          <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
        end else begin
            mul_start_reg <= gnt_any;
            if (gnt_any) begin
                ptr_reg    <= gnt_id;
                mcand_reg  <= mcand_slice[gnt_id];
                mplier_reg <= mplier_slice[gnt_id];
            end
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg       <= ptr_inc(rd_ptr_reg);
                resp_product_reg <= mul_product;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            busy_reg       <= busy_next;
            resp_valid_reg <= pop ? (ONE_HOT << head_id) : '0;
            if (err_event) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign busy         = busy_reg;
    assign resp_valid   = resp_valid_reg;
    assign resp_product = resp_product_reg;
    assign mul_start    = mul_start_reg;
    assign mul_mcand    = mcand_reg;
    assign mul_mplier   = mplier_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed scenarios against mult_arbiter with a fixed-latency multiplier model.
module tb_mult_arbiter;
    localparam int NR = 4;
    localparam int W  = 64;
    localparam int L  = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR*W-1:0] req_mcand = '0;
    logic [NR*W-1:0] req_mplier = '0;
    logic [NR-1:0]   gnt, resp_valid, busy;
    logic [W-1:0]    resp_product, mul_mcand, mul_mplier, mul_product;
    logic            mul_start, mul_done, err;
    logic            force_done = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    mult_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LATENCY(L)) dut (
        .clock(clock), .reset(reset), .req(req), .req_mcand(req_mcand),
        .req_mplier(req_mplier), .gnt(gnt), .resp_valid(resp_valid),
        .resp_product(resp_product), .mul_start(mul_start), .mul_mcand(mul_mcand),
        .mul_mplier(mul_mplier), .mul_product(mul_product), .mul_done(mul_done),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    // Multiplier model: start seen in cycle S gives done in cycle S+L.
    logic [L-1:0] pipe_v;
    logic [W-1:0] pipe_p [L];
    always @(posedge clock) begin
        if (reset) begin
            pipe_v <= '0;
            for (int k = 0; k < L; k++) pipe_p[k] <= '0;
        end else begin
            pipe_v    <= {pipe_v[L-2:0], mul_start};
            pipe_p[0] <= mul_mcand * mul_mplier;
            for (int k = 1; k < L; k++) pipe_p[k] <= pipe_p[k-1];
        end
    end
    assign mul_done    = pipe_v[L-1] | force_done;
    assign mul_product = pipe_p[L-1];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_mcand[i*W +: W]  = a;
        req_mplier[i*W +: W] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        force_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        req = '0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < NR; i++) set_op(i, 64'd9, 64'd9);
        tick();
        tick();
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        n_cmp++; if (busy !== 4'b0000) begin n_err++; $display("FAIL reset_busy got=%b want=0000", busy); end
        n_cmp++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL reset_resp_valid got=%b want=0000", resp_valid); end
        n_cmp++; if (mul_start !== 1'b0) begin n_err++; $display("FAIL reset_mul_start got=%b want=0", mul_start); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b want=0", err); end
        n_cmp++; if (mul_mcand !== 64'd0 || mul_mplier !== 64'd0) begin n_err++; $display("FAIL reset_operands got=%h/%h want=0/0", mul_mcand, mul_mplier); end
        n_cmp++; if (resp_product !== 64'd0) begin n_err++; $display("FAIL reset_product got=%h want=0", resp_product); end
        req = '0;
        reset = 1'b0;
        tick();
        $display("test_reset: done");
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        set_op(2, 64'd3, 64'd5);
        #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt got=%b want=0100", gnt); end
        tick();
        req = '0;
        set_op(2, 64'd100, 64'd100);
        #1;
        n_cmp++; if (mul_start !== 1'b1) begin n_err++; $display("FAIL single_start got=%b want=1", mul_start); end
        n_cmp++; if (mul_mcand !== 64'd3 || mul_mplier !== 64'd5) begin n_err++; $display("FAIL single_operands got=%0d/%0d want=3/5", mul_mcand, mul_mplier); end
        n_cmp++; if (busy !== 4'b0100) begin n_err++; $display("FAIL single_busy_t1 got=%b want=0100", busy); end
        for (int c = 2; c <= 9; c++) begin
            tick();
            n_cmp++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL single_early_resp c=%0d got=%b want=0000", c, resp_valid); end
            n_cmp++; if (busy !== 4'b0100) begin n_err++; $display("FAIL single_busy c=%0d got=%b want=0100", c, busy); end
            if (c == 2) begin
                n_cmp++; if (mul_start !== 1'b0) begin n_err++; $display("FAIL single_start_pulse got=%b want=0", mul_start); end
            end
        end
        tick();
        n_cmp++; if (resp_valid !== 4'b0100) begin n_err++; $display("FAIL single_resp_valid got=%b want=0100", resp_valid); end
        n_cmp++; if (resp_product !== 64'd15) begin n_err++; $display("FAIL single_product got=%0d want=15", resp_product); end
        n_cmp++; if (busy !== 4'b0000) begin n_err++; $display("FAIL single_busy_clear got=%b want=0000", busy); end
        tick();
        n_cmp++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL single_resp_pulse got=%b want=0000", resp_valid); end
        $display("test_single: req2 3*5 -> 15");
    endtask

    task automatic test_all_four();
        logic [NR-1:0] exp_g [5];
        logic [NR-1:0] exp_v;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0000;
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, 64'(i + 1), 64'(i + 1));
        req = 4'b1111;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) tick();
            #1;
            n_cmp++; if (gnt !== exp_g[c]) begin n_err++; $display("FAIL four_gnt c=%0d got=%b want=%b", c, gnt, exp_g[c]); end
            if (c > 0) begin
                n_cmp++; if (mul_start !== 1'b1 || mul_mcand !== 64'(c)) begin n_err++; $display("FAIL four_issue c=%0d got=%b/%0d want=1/%0d", c, mul_start, mul_mcand, c); end
            end
        end
        req = '0;
        for (int k = 0; k < 6; k++) tick();
        for (int c = 0; c < NR; c++) begin
            exp_v = 4'b0001 << c;
            n_cmp++; if (resp_valid !== exp_v) begin n_err++; $display("FAIL four_resp_valid c=%0d got=%b want=%b", c, resp_valid, exp_v); end
            n_cmp++; if (resp_product !== 64'((c + 1) * (c + 1))) begin n_err++; $display("FAIL four_product c=%0d got=%0d want=%0d", c, resp_product, (c + 1) * (c + 1)); end
            tick();
        end
        n_cmp++; if (resp_valid !== 4'b0000 || busy !== 4'b0000) begin n_err++; $display("FAIL four_idle got=%b/%b want=0000/0000", resp_valid, busy); end
        $display("test_all_four: products 1,4,9,16");
    endtask

    task automatic test_hold();
        do_reset();
        req = 4'b0010;
        set_op(1, 64'd7, 64'd6);
        #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL hold_gnt1 got=%b want=0010", gnt); end
        tick();
        req = 4'b1010;
        set_op(3, 64'd2, 64'd9);
        #1;
        n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL hold_gnt3 got=%b want=1000", gnt); end
        tick();
        req = 4'b0010;
        for (int c = 2; c <= 9; c++) begin
            if (c > 2) tick();
            #1;
            n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL hold_no_regrant c=%0d got=%b want=0000", c, gnt); end
        end
        tick();
        #1;
        n_cmp++; if (resp_valid !== 4'b0010 || resp_product !== 64'd42) begin n_err++; $display("FAIL hold_resp1 got=%b/%0d want=0010/42", resp_valid, resp_product); end
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL hold_regrant got=%b want=0010", gnt); end
        tick();
        req = '0;
        #1;
        n_cmp++; if (resp_valid !== 4'b1000 || resp_product !== 64'd18) begin n_err++; $display("FAIL hold_resp3 got=%b/%0d want=1000/18", resp_valid, resp_product); end
        n_cmp++; if (busy !== 4'b0010) begin n_err++; $display("FAIL hold_busy got=%b want=0010", busy); end
        drain(12);
        $display("test_hold: req1 regranted on its resp cycle");
    endtask

    task automatic test_fair();
        logic [NR-1:0] exp_g;
        int g0, g2;
        g0 = 0;
        g2 = 0;
        do_reset();
        req = 4'b0100;
        set_op(2, 64'd1, 64'd1);
        #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL fair_setup_gnt got=%b want=0100", gnt); end
        tick();
        drain(12);
        req = 4'b0101;
        set_op(0, 64'd2, 64'd2);
        set_op(2, 64'd3, 64'd3);
        for (int c = 0; c < 100; c++) begin
            #1;
            exp_g = (c % 10 == 0) ? 4'b0001 : ((c % 10 == 1) ? 4'b0100 : 4'b0000);
            n_cmp++; if (gnt !== exp_g) begin n_err++; $display("FAIL fair_gnt c=%0d got=%b want=%b", c, gnt, exp_g); end
            if (gnt[0]) g0++;
            if (gnt[2]) g2++;
            tick();
        end
        n_cmp++; if (g0 != 10 || g2 != 10) begin n_err++; $display("FAIL fair_counts got=%0d/%0d want=10/10", g0, g2); end
        drain(12);
        $display("test_fair: grants req0=%0d req2=%0d", g0, g2);
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        set_op(1, 64'd4, 64'd4);
        #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL mid_gnt got=%b want=0010", gnt); end
        tick();
        req = '0;
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1;
        tick();
        n_cmp++; if (busy !== 4'b0000 || mul_start !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL mid_flush got=%b/%b/%b want=0000/0/0", busy, mul_start, err); end
        tick();
        reset = 1'b0;
        req = 4'b1000;
        set_op(3, 64'd3, 64'd3);
        #1;
        n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL mid_first_gnt got=%b want=1000", gnt); end
        for (int c = 1; c <= 12; c++) begin
            tick();
            req = '0;
            if (c == 10) begin
                n_cmp++; if (resp_valid !== 4'b1000 || resp_product !== 64'd9) begin n_err++; $display("FAIL mid_resp got=%b/%0d want=1000/9", resp_valid, resp_product); end
            end else begin
                n_cmp++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL mid_stale c=%0d got=%b want=0000", c, resp_valid); end
            end
        end
        $display("test_reset_mid: flushed op discarded, req3 3*3 -> 9");
    endtask

    task automatic test_spurious_done();
        do_reset();
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL spur_err got=%b want=1", err); end
        n_cmp++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL spur_resp got=%b want=0000", resp_valid); end
        for (int k = 0; k < 3; k++) tick();
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL spur_sticky got=%b want=1", err); end
        req = 4'b0001;
        set_op(0, 64'd5, 64'd7);
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL spur_gnt got=%b want=0001", gnt); end
        tick();
        req = '0;
        for (int k = 0; k < 9; k++) tick();
        n_cmp++; if (resp_valid !== 4'b0001 || resp_product !== 64'd35) begin n_err++; $display("FAIL spur_resp_after got=%b/%0d want=0001/35", resp_valid, resp_product); end
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL spur_err_end got=%b want=1", err); end
        $display("test_spurious_done: err sticky, 5*7 -> 35");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_hold();
        test_fair();
        test_reset_mid();
        test_spurious_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
